led_blink_sched: RTL

Controller that sequences the LED blink-source multiplexer: it generates the 1 Hz and 2 Hz blink waveforms from the system clock and synchronizes and debounces the select switch. It commits a source change only at a phase where both waveforms are low, so GPIO_LED1 never glitches or shows a runt pulse. It sits between the board GPIO (DIP switch, LED) and the system clock domain.

---
 rtl/led_blink_sched.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/led_blink_sched.sv
// LED blink-source scheduler: 1 Hz / 2 Hz waveform generator with glitch-free source switching.
// Optional switch debouncer is built when DEBOUNCE_EN is defined; otherwise REQ follows the synchronizer.
module led_blink_sched #(
    parameter int CLK_FREQ   = 50000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic GPIO_DIP1,
    output logic GPIO_LED1,
    output logic SEL_ACTIVE,
    output logic SWITCH_PENDING
);

    localparam int Q      = CLK_FREQ / 4;
    localparam int PERIOD = 4 * Q;
    localparam int PH_W   = $clog2(PERIOD);

    localparam logic [PH_W-1:0] PH_Q    = PH_W'(Q);
    localparam logic [PH_W-1:0] PH_2Q   = PH_W'(2 * Q);
    localparam logic [PH_W-1:0] PH_3Q   = PH_W'(3 * Q);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);

    generate
        if (((CLK_FREQ % 4) != 0) || (CLK_FREQ < 4) || (DEB_CYCLES < 1)) begin : g_bad_params
            $error("led_blink_sched: invalid CLK_FREQ or DEB_CYCLES");
        end
    endgenerate

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    logic [PH_W-1:0] r_ph;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_req;
    logic            r_sel;
    logic            r_led;
    state_t          r_state;
    state_t          w_state_next;
    logic            w_sel_next;
    logic            w_slow;
    logic            w_fast;

    // Free-running phase: never disturbed by a source switch.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ph <= '0;
        end else if (r_ph == PH_LAST) begin
            r_ph <= '0;
        end else begin
            r_ph <= r_ph + 1'b1;
        end
    end

    assign w_slow = (r_ph < PH_2Q);
    assign w_fast = (r_ph < PH_Q) || ((r_ph >= PH_2Q) && (r_ph < PH_3Q));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= GPIO_DIP1;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DCNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_CYCLES - 1);

    logic [DCNT_W-1:0] r_dcnt;

    // Any return of SYNC to REQ restarts the stability count.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_dcnt <= '0;
            r_req  <= 1'b0;
        end else if (r_sync2 == r_req) begin
            r_dcnt <= '0;
        end else if (r_dcnt == DCNT_LAST) begin
            r_req  <= r_sync2;
            r_dcnt <= '0;
        end else begin
            r_dcnt <= r_dcnt + 1'b1;
        end
    end
`else
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_req <= 1'b0;
        end else begin
            r_req <= r_sync2;
        end
    end
`endif

    // Commit only at the start of quarter 3, where both waveforms are low;
    // a withdrawn request takes priority over the commit.
    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        case (r_state)
            ST_RUN: begin
                if (r_req != r_sel) begin
                    w_state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (r_req == r_sel) begin
                    w_state_next = ST_RUN;
                end else if (r_ph == PH_3Q) begin
                    w_sel_next   = r_req;
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_RUN;
            r_sel   <= 1'b0;
            r_led   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_led   <= r_sel ? w_fast : w_slow;
        end
    end

    assign GPIO_LED1      = r_led;
    assign SEL_ACTIVE     = r_sel;
    assign SWITCH_PENDING = (r_state == ST_PEND);

endmodule
